muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
Multi-cycle sequencer for the RV32M extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU). It uses the shared 32-bit ALU as its add/subtract engine, driving shift-add multiplication and restoring division one bit per cycle. It sits beside the EX stage: it accepts an operation, holds `busy` so the pipeline stalls, and returns a result with a one-cycle `done` pulse.

Parameters:
XLEN, 32, operand/result width (only 32 supported)
ITERS, 32, iteration count, equal to XLEN

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  request; sampled only in IDLE
funct3  input  3  M-extension funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
rs1  input  32  operand A, captured on accepted start
rs2  input  32  operand B, captured on accepted start
flush  input  1  abort the current operation (exception/interrupt)
busy  output  1  high from the cycle after start is accepted through the DONE cycle
done  output  1  one-cycle pulse; result is valid in this cycle
result  output  32  final value, held until the next accepted start
alu_op  output  4  ALU operation code (`ALU_ADD`/`ALU_SUB` from defines.v)
alu_a  output  32  ALU operand A
alu_b  output  32  ALU operand B
alu_c  input  32  ALU result (combinational from alu_op/alu_a/alu_b)

Behaviour:
- Clock and reset: one clock, `clk`. Reset is synchronous and active-low on `rst_n`. Reset → state IDLE; busy=0, done=0, result=0; all internal registers 0. Reset takes priority over flush and start and may land in any state.
- States:
  - IDLE: start=1 → capture operands, go to PREP.
  - PREP: classify the operation. Divisor==0 or signed overflow → go to DONE. Otherwise → ITER, count=0.
  - ITER: 32 cycles; count==31 → FIX.
  - FIX: apply sign fix-up → DONE.
  - DONE: done=1 → IDLE.
- Idle ALU drive: in every state except ITER, alu_op=`ALU_ADD`, alu_a=0, alu_b=0.
- Operand capture and sign handling in PREP:
  - Signed operands are converted to magnitudes by internal two's-complement negation. MULH: both signed. MULHSU: rs1 signed, rs2 unsigned. DIV/REM: both signed.
  - Record neg_q = sign(rs1) XOR sign(rs2) for DIV/MUL*, and neg_r = sign(rs1) for REM.
- Multiply iteration:
  - Registers: 64-bit {hi,lo}, with lo initialised to the multiplier and hi=0.
  - Each ITER cycle drives alu_op=`ALU_ADD`, alu_a=hi, alu_b = lo[0] ? multiplicand : 0.
  - carry = (alu_c < hi), unsigned compare.
  - Update: {hi,lo} ← {carry, alu_c, lo[31:1]}.
- Divide iteration:
  - Registers: rem (33-bit), quo (32-bit).
  - Each cycle: shifted = {rem[31:0], quo[31]}.
  - Drive alu_op=`ALU_SUB`, alu_a=shifted[31:0], alu_b=divisor.
  - ge = shifted[32] | (shifted[31:0] >= divisor).
  - Update: rem ← ge ? {1'b0, alu_c} : shifted; quo ← {quo[30:0], ge}.
- FIX:
  - If neg_q, negate the 64-bit product or the quotient internally. If neg_r, negate the remainder.
  - MUL selects lo. MULH/MULHSU/MULHU select hi. DIV/DIVU select quo. REM/REMU select rem[31:0].
  - The selected value is registered into result.
- Special cases, decided in PREP and skipping ITER:
  - Divisor 0: DIV/DIVU result=0xFFFFFFFF; REM/REMU result=rs1.
  - DIV with rs1=0x80000000 and rs2=0xFFFFFFFF: result=0x80000000. The matching REM: result=0.
  - Multiply by 0 is not special-cased and takes the full path.
- Latency, with start accepted at cycle 0:
  - Normal: done at cycle 35; busy high in cycles 1–35; IDLE again at cycle 36.
  - Special case: done at cycle 2.
- Start rules:
  - start while busy is ignored and no operands are captured.
  - start in the DONE cycle is ignored. start in the IDLE cycle immediately after DONE is accepted, so back-to-back operations have 36-cycle spacing.
- flush:
  - Any non-IDLE state → IDLE on the next edge; busy=0 and no done pulse. result keeps its previous value.
  - flush in IDLE overrides a same-cycle start, which is then not accepted.
  - flush in the DONE cycle: the done pulse is still emitted this cycle and result is updated.

Test Plan:
1. Reset: rst_n=0 mid-ITER for 1 cycle → next cycle busy=0, done=0, result=0; alu_op=`ALU_ADD`, alu_a=alu_b=0.
2. MUL/MULHU: rs1=0xFFFFFFFF, rs2=0xFFFFFFFF. MULHU → done at cycle 35, result=0xFFFFFFFE. MUL → result=0x00000001. MULH → result=0x00000000.
3. DIV/REM signed: rs1=0xFFFFFFF9 (−7), rs2=2. DIV → result=0xFFFFFFFD (−3). REM → result=0xFFFFFFFF (−1). DIVU with the same operands → result=0x7FFFFFFC.
4. Special cases: DIVU 100/0 → done at cycle 2, result=0xFFFFFFFF. REMU 100/0 → result=100. DIV 0x80000000/0xFFFFFFFF → result=0x80000000. REM of the same → result=0.
5. Handshake: start held high for 40 cycles with MUL 3×5 → exactly 2 operations accepted (cycles 0 and 36); done pulses at 35 and 71; result=15 held between them.
6. Flush: flush at cycle 10 of DIVU 1000/7 → busy=0 at cycle 11, no done, result unchanged. A new DIVU started at cycle 12 → result=142, done at cycle 47.

Source files
------------

// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: operation request/response and shared-ALU hookup
// for the RV32M multi-cycle sequencer
interface muldiv_seq_if;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [3:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_c;

  modport master (
    output start, funct3, rs1, rs2, flush, alu_c,
    input  busy, done, result, alu_op, alu_a, alu_b
  );

  modport slave (
    input  start, funct3, rs1, rs2, flush, alu_c,
    output busy, done, result, alu_op, alu_a, alu_b
  );
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq: RV32M multiply/divide sequencer, one bit per cycle,
// shift-add multiply and restoring divide on the shared ALU
module muldiv_seq #(
  parameter int XLEN  = 32,
  parameter int ITERS = 32
) (
  input logic         clk,
  input logic         rst_n,
  muldiv_seq_if.slave bus
);

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam int CW = $clog2(ITERS);
  localparam logic [CW-1:0] LAST = CW'(ITERS - 1);
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_ITER,
    S_FIX,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [2:0]      op_q, op_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            negq_q, negq_d;
  logic            negr_q, negr_d;
  logic [XLEN-1:0] res_q, res_d;

  logic            sgn_a;
  logic            sgn_b;
  logic            is_div;
  logic            is_rem;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            div_zero;
  logic            div_ovf;

  logic [3:0]      alu_op;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [XLEN-1:0] shl;
  logic            ge;
  logic            carry;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0] quo_f;
  logic [XLEN-1:0] rem_f;

  // operand signedness per funct3
  always_comb begin
    sgn_a = 1'b0;
    sgn_b = 1'b0;
    unique case (op_q)
      3'd1: begin
        sgn_a = 1'b1;
        sgn_b = 1'b1;
      end
      3'd2: sgn_a = 1'b1;
      3'd4, 3'd6: begin
        sgn_a = 1'b1;
        sgn_b = 1'b1;
      end
      default: ;
    endcase
  end

  assign is_div   = op_q[2];
  assign is_rem   = op_q[2] & op_q[1];
  assign a_neg    = sgn_a & a_q[XLEN-1];
  assign b_neg    = sgn_b & b_q[XLEN-1];
  assign a_mag    = a_neg ? -a_q : a_q;
  assign b_mag    = b_neg ? -b_q : b_q;
  assign div_zero = is_div & (b_q == '0);
  assign div_ovf  = is_div & sgn_a
                  & (a_q == SMIN) & (b_q == '1);

  // FSM next state; flush aborts any active operation
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (bus.start && !bus.flush) state_d = S_PREP;
      S_PREP: state_d = (div_zero || div_ovf) ? S_DONE : S_ITER;
      S_ITER: if (cnt_q == LAST) state_d = S_FIX;
      S_FIX:  state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (bus.flush && state_q != S_IDLE) state_d = S_IDLE;
  end

  // datapath next state and ALU drive
  always_comb begin
    op_d   = op_q;
    a_d    = a_q;
    b_d    = b_q;
    acc_d  = acc_q;
    lo_d   = lo_q;
    cnt_d  = cnt_q;
    negq_d = negq_q;
    negr_d = negr_q;
    res_d  = res_q;
    alu_op = ALU_ADD;
    alu_a  = '0;
    alu_b  = '0;
    shl    = {acc_q[XLEN-2:0], lo_q[XLEN-1]};
    ge     = 1'b0;
    carry  = 1'b0;
    prod   = negq_q ? -{acc_q, lo_q} : {acc_q, lo_q};
    quo_f  = negq_q ? -lo_q : lo_q;
    rem_f  = negr_q ? -acc_q : acc_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.flush) begin
          op_d = bus.funct3;
          a_d  = bus.rs1;
          b_d  = bus.rs2;
        end
      end
      S_PREP: begin
        if (div_zero) begin
          if (!bus.flush) res_d = op_q[1] ? a_q : '1;
        end else if (div_ovf) begin
          if (!bus.flush) res_d = op_q[1] ? '0 : SMIN;
        end else begin
          cnt_d  = '0;
          negq_d = a_neg ^ b_neg;
          negr_d = a_neg & is_rem;
          b_d    = b_mag;
          acc_d  = '0;
          lo_d   = a_mag;
        end
      end
      S_ITER: begin
        cnt_d = cnt_q + 1'b1;
        if (is_div) begin
          alu_op = ALU_SUB;
          alu_a  = shl;
          alu_b  = b_q;
          ge     = acc_q[XLEN-1] | (shl >= b_q);
          acc_d  = ge ? bus.alu_c : shl;
          lo_d   = {lo_q[XLEN-2:0], ge};
        end else begin
          alu_op = ALU_ADD;
          alu_a  = acc_q;
          alu_b  = lo_q[0] ? b_q : '0;
          carry  = bus.alu_c < acc_q;
          acc_d  = {carry, bus.alu_c[XLEN-1:1]};
          lo_d   = {bus.alu_c[0], lo_q[XLEN-1:1]};
        end
      end
      S_FIX: begin
        if (!bus.flush) begin
          unique case (op_q)
            3'd0:             res_d = prod[XLEN-1:0];
            3'd1, 3'd2, 3'd3: res_d = prod[2*XLEN-1:XLEN];
            3'd4, 3'd5:       res_d = quo_f;
            default:          res_d = rem_f;
          endcase
        end
      end
      default: ;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      lo_q   <= '0;
      cnt_q  <= '0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
      res_q  <= '0;
    end else begin
      op_q   <= op_d;
      a_q    <= a_d;
      b_q    <= b_d;
      acc_q  <= acc_d;
      lo_q   <= lo_d;
      cnt_q  <= cnt_d;
      negq_q <= negq_d;
      negr_q <= negr_d;
      res_q  <= res_d;
    end
  end

  assign bus.busy   = (state_q != S_IDLE);
  assign bus.done   = (state_q == S_DONE);
  assign bus.result = res_q;
  assign bus.alu_op = alu_op;
  assign bus.alu_a  = alu_a;
  assign bus.alu_b  = alu_b;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed checks of the RV32M sequencer
// against hand-computed results and cycle latencies
module tb_muldiv_seq;
  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;
  int   lat;
  int   ndone;
  int   d1;
  int   d2;
  logic [31:0] res;

  muldiv_seq_if bus ();

  muldiv_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always_comb
    bus.alu_c = (bus.alu_op == 4'd1) ? bus.alu_a - bus.alu_b
                                     : bus.alu_a + bus.alu_b;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, output int l,
                       output logic [31:0] r);
    @(negedge clk);
    bus.funct3 = f3;
    bus.rs1    = a;
    bus.rs2    = b;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_c1", {31'b0, bus.busy}, 32'd1);
    l = 1;
    while (bus.done !== 1'b1 && l < 100) begin
      @(negedge clk);
      l++;
    end
    r = bus.result;
  endtask

  initial begin
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.flush  = 1'b0;
    bus.funct3 = 3'd0;
    bus.rs1    = '0;
    bus.rs2    = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_done", {31'b0, bus.done}, 32'd0);
    chk("rst_result", bus.result, 32'd0);
    rst_n = 1'b1;

    do_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, res);
    chk("mulhu_lat", lat, 32'd35);
    chk("mulhu_res", res, 32'hFFFFFFFE);
    do_op(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, res);
    chk("mul_res", res, 32'h00000001);
    do_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, res);
    chk("mulh_res", res, 32'h00000000);
    do_op(3'd2, 32'hFFFFFFFF, 32'h00000002, lat, res);
    chk("mulhsu_res", res, 32'hFFFFFFFF);
    do_op(3'd3, 32'h00000000, 32'hDEADBEEF, lat, res);
    chk("mul0_lat", lat, 32'd35);
    chk("mul0_res", res, 32'h00000000);

    do_op(3'd3, 32'h12345678, 32'h00010000, lat, res);
    chk("pre_rst_res", res, 32'h00001234);
    @(negedge clk);
    bus.funct3 = 3'd3;
    bus.rs1    = 32'hFFFFFFFF;
    bus.rs2    = 32'hFFFFFFFF;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("iter_alu_b", bus.alu_b, 32'hFFFFFFFF);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("mid_rst_done", {31'b0, bus.done}, 32'd0);
    chk("mid_rst_result", bus.result, 32'd0);
    chk("mid_rst_op", {28'b0, bus.alu_op}, 32'd0);
    chk("mid_rst_a", bus.alu_a, 32'd0);
    chk("mid_rst_b", bus.alu_b, 32'd0);
    rst_n = 1'b1;

    do_op(3'd4, 32'hFFFFFFF9, 32'd2, lat, res);
    chk("div_lat", lat, 32'd35);
    chk("div_res", res, 32'hFFFFFFFD);
    do_op(3'd6, 32'hFFFFFFF9, 32'd2, lat, res);
    chk("rem_res", res, 32'hFFFFFFFF);
    do_op(3'd5, 32'hFFFFFFF9, 32'd2, lat, res);
    chk("divu_res", res, 32'h7FFFFFFC);
    do_op(3'd7, 32'hFFFFFFF9, 32'd10, lat, res);
    chk("remu_res", res, 32'd9);

    do_op(3'd5, 32'd100, 32'd0, lat, res);
    chk("divu0_lat", lat, 32'd2);
    chk("divu0_res", res, 32'hFFFFFFFF);
    do_op(3'd7, 32'd100, 32'd0, lat, res);
    chk("remu0_res", res, 32'd100);
    do_op(3'd4, 32'h80000000, 32'hFFFFFFFF, lat, res);
    chk("ovf_lat", lat, 32'd2);
    chk("ovf_div_res", res, 32'h80000000);
    do_op(3'd6, 32'h80000000, 32'hFFFFFFFF, lat, res);
    chk("ovf_rem_res", res, 32'd0);

    @(negedge clk);
    bus.funct3 = 3'd0;
    bus.rs1    = 32'd3;
    bus.rs2    = 32'd5;
    bus.start  = 1'b1;
    ndone = 0;
    d1    = 0;
    d2    = 0;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        ndone++;
        if (ndone == 1) d1 = k;
        else d2 = k;
      end
      if (k == 36) chk("hs_idle36", {31'b0, bus.busy}, 32'd0);
      if (k == 50) chk("hs_hold", bus.result, 32'd15);
      if (k == 40) bus.start = 1'b0;
    end
    chk("hs_ndone", ndone, 32'd2);
    chk("hs_done1", d1, 32'd35);
    chk("hs_done2", d2, 32'd71);
    chk("hs_res", bus.result, 32'd15);

    @(negedge clk);
    bus.funct3 = 3'd5;
    bus.rs1    = 32'd1000;
    bus.rs2    = 32'd7;
    bus.start  = 1'b1;
    ndone = 0;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (k == 1) bus.start = 1'b0;
      if (bus.done === 1'b1) ndone++;
      if (k == 10) bus.flush = 1'b1;
      if (k == 11) begin
        bus.flush = 1'b0;
        chk("fl_busy", {31'b0, bus.busy}, 32'd0);
      end
    end
    chk("fl_nodone", ndone, 32'd0);
    chk("fl_res", bus.result, 32'd15);
    do_op(3'd5, 32'd1000, 32'd7, lat, res);
    chk("fl_new_lat", lat, 32'd35);
    chk("fl_new_res", res, 32'd142);

    @(negedge clk);
    bus.start = 1'b1;
    bus.flush = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    chk("idle_flush", {31'b0, bus.busy}, 32'd0);
    chk("idle_flush_res", bus.result, 32'd142);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
